// File: rtl/riscv_fetch_stage.sv
// rtl/riscv_fetch_stage.sv - IF stage and IF/ID register: PC, redirect/stall/halt control, fetch and bubble counters
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] TARGET_ADDR,
    input  logic [31:0] INSTR,
    output logic [31:0] INSTR_ADDR,
    output logic [31:0] IF_ID_INSTR,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC_PLUS4,
    output logic        IF_ID_VALID,
    output logic        HALTED,
    output logic        MISALIGN,
    output logic [31:0] FETCH_CNT,
    output logic [31:0] BUBBLE_CNT
);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] pc_plus4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        valid_d      = valid_q;
        misalign_d   = misalign_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        // Redirect wins over stall and halt; TARGET_ADDR is only looked at here.
        if (FLUSH) begin
            state_d      = ST_RUN;
            pc_d         = {TARGET_ADDR[31:2], 2'b00};
            instr_d      = NOP_INSTR;
            valid_d      = 1'b0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
            misalign_d   = misalign_q | (TARGET_ADDR[1:0] != 2'b00);
        end else if (!STALL) begin
            case (state_q)
                ST_RUN: begin
                    instr_d     = INSTR;
                    ifid_pc_d   = pc_q;
                    ifid_pc4_d  = pc_plus4;
                    valid_d     = 1'b1;
                    fetch_cnt_d = sat_inc(fetch_cnt_q);
                    if (INSTR == HALT_INSTR) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                ST_HALT: begin
                    instr_d      = NOP_INSTR;
                    valid_d      = 1'b0;
                    bubble_cnt_d = sat_inc(bubble_cnt_q);
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            valid_q      <= 1'b0;
            misalign_q   <= 1'b0;
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            valid_q      <= valid_d;
            misalign_q   <= misalign_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign INSTR_ADDR     = pc_q;
    assign IF_ID_INSTR    = instr_q;
    assign IF_ID_PC       = ifid_pc_q;
    assign IF_ID_PC_PLUS4 = ifid_pc4_q;
    assign IF_ID_VALID    = valid_q;
    assign HALTED         = (state_q == ST_HALT);
    assign MISALIGN       = misalign_q;
    assign FETCH_CNT      = fetch_cnt_q;
    assign BUBBLE_CNT     = bubble_cnt_q;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb/tb_riscv_fetch_stage.sv - directed and randomized checks of riscv_fetch_stage against a reference model
module tb_riscv_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        CLK = 1'b0;
    logic        RSTN, STALL, FLUSH;
    logic [31:0] TARGET_ADDR, INSTR;
    logic [31:0] INSTR_ADDR, IF_ID_INSTR, IF_ID_PC, IF_ID_PC_PLUS4, FETCH_CNT, BUBBLE_CNT;
    logic        IF_ID_VALID, HALTED, MISALIGN;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_fc, m_bc;
    logic        m_valid, m_halt, m_mis;

    riscv_fetch_stage dut (
        .CLK(CLK), .RSTN(RSTN), .STALL(STALL), .FLUSH(FLUSH),
        .TARGET_ADDR(TARGET_ADDR), .INSTR(INSTR), .INSTR_ADDR(INSTR_ADDR),
        .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_PC(IF_ID_PC), .IF_ID_PC_PLUS4(IF_ID_PC_PLUS4),
        .IF_ID_VALID(IF_ID_VALID), .HALTED(HALTED), .MISALIGN(MISALIGN),
        .FETCH_CNT(FETCH_CNT), .BUBBLE_CNT(BUBBLE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inc_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic model(input logic rstn, stall, flush, input logic [31:0] tgt, instr);
        if (!rstn) begin
            m_pc = 0; m_instr = NOP; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0;
            m_halt = 0; m_mis = 0; m_fc = 0; m_bc = 0;
        end else if (flush) begin
            m_pc = tgt & ~32'd3;
            m_instr = NOP; m_valid = 0;
            m_bc = inc_sat(m_bc);
            m_mis = m_mis | (tgt % 4 != 0);
            m_halt = 0;
        end else if (stall) begin
            // nothing moves
        end else if (m_halt) begin
            m_instr = NOP; m_valid = 0;
            m_bc = inc_sat(m_bc);
        end else begin
            m_instr = instr; m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_valid = 1;
            m_fc = inc_sat(m_fc);
            if (instr == EBRK) m_halt = 1;
            else m_pc = m_pc + 4;
        end
    endtask

    task automatic compare_all();
        check("instr_addr", INSTR_ADDR, m_pc);
        check("if_id_instr", IF_ID_INSTR, m_instr);
        check("if_id_pc", IF_ID_PC, m_ifpc);
        check("if_id_pc_plus4", IF_ID_PC_PLUS4, m_ifpc4);
        check("if_id_valid", {31'd0, IF_ID_VALID}, {31'd0, m_valid});
        check("halted", {31'd0, HALTED}, {31'd0, m_halt});
        check("misalign", {31'd0, MISALIGN}, {31'd0, m_mis});
        check("fetch_cnt", FETCH_CNT, m_fc);
        check("bubble_cnt", BUBBLE_CNT, m_bc);
    endtask

    task automatic step(input logic rstn, stall, flush, input logic [31:0] tgt, instr);
        RSTN = rstn; STALL = stall; FLUSH = flush; TARGET_ADDR = tgt; INSTR = instr;
        @(posedge CLK);
        model(rstn, stall, flush, tgt, instr);
        #1;
        compare_all();
    endtask

    initial begin
        logic        r_st, r_fl, r_rn;
        logic [31:0] r_tg, r_in;

        RSTN = 0; STALL = 0; FLUSH = 0; TARGET_ADDR = 0; INSTR = 0;
        #2;
        step(0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 1, 32'h0, EBRK);
        check("reset_pc_const", INSTR_ADDR, 32'h0);
        check("reset_nop_const", IF_ID_INSTR, NOP);

        // free run: 0 -> 4 -> 8
        step(1, 0, 0, 32'hx, 32'h0000_0093);
        check("edge1_pc", IF_ID_PC, 32'h0);
        check("edge1_pc4", IF_ID_PC_PLUS4, 32'h4);
        check("edge1_fcnt", FETCH_CNT, 32'd1);
        step(1, 0, 0, 32'hx, 32'h0010_0113);
        check("addr_8", INSTR_ADDR, 32'h8);

        // stall three cycles at PC=8, then release
        repeat (3) step(1, 1, 0, 32'hx, 32'h0020_0193);
        check("stall_addr", INSTR_ADDR, 32'h8);
        step(1, 0, 0, 32'hx, 32'h0020_0193);
        check("release_pc", IF_ID_PC, 32'h8);

        // flush beats stall
        step(1, 1, 1, 32'h40, 32'h0030_0213);
        check("flush_addr", INSTR_ADDR, 32'h40);
        check("flush_bcnt", BUBBLE_CNT, 32'd1);

        // misaligned redirect
        step(1, 0, 1, 32'h43, 32'h0);
        check("mis_addr", INSTR_ADDR, 32'h40);
        check("mis_flag", {31'd0, MISALIGN}, 32'd1);
        step(1, 0, 0, 32'hx, 32'h0040_0293);

        // halt at 0x20
        step(1, 0, 1, 32'h1C, 32'h0);
        step(1, 0, 0, 32'hx, 32'h0050_0313);
        step(1, 0, 0, 32'hx, EBRK);
        check("halt_flag", {31'd0, HALTED}, 32'd1);
        check("halt_addr", INSTR_ADDR, 32'h20);
        repeat (2) step(1, 0, 0, 32'hx, EBRK);
        step(1, 1, 0, 32'hx, EBRK);
        step(1, 0, 1, 32'h0, EBRK);
        check("resume_addr", INSTR_ADDR, 32'h0);
        step(1, 0, 0, 32'hx, 32'h0000_0093);

        // flush + stall + EBREAK together: no halt
        step(1, 1, 1, 32'h100, EBRK);
        check("combo_halted", {31'd0, HALTED}, 32'd0);

        // PC wrap at top of address space
        step(1, 0, 1, 32'hFFFF_FFFC, 32'h0);
        step(1, 0, 0, 32'hx, 32'h0000_0093);
        check("wrap_addr", INSTR_ADDR, 32'h0);

        // reset mid-halt with stall
        step(1, 0, 0, 32'hx, EBRK);
        step(0, 1, 0, 32'hx, EBRK);
        check("rst_halted", {31'd0, HALTED}, 32'd0);

        // randomized traffic, X on TARGET_ADDR whenever FLUSH is low
        for (int i = 0; i < 400; i++) begin
            r_rn = ($urandom_range(0, 99) >= 2);
            r_st = ($urandom_range(0, 99) < 25);
            r_fl = ($urandom_range(0, 99) < 10);
            r_tg = r_fl ? $urandom : 32'hx;
            r_in = ($urandom_range(0, 99) < 10) ? EBRK : $urandom;
            step(r_rn, r_st, r_fl, r_tg, r_in);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
